// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, the single write port and init status.
// Handshake: there is no back-pressure. A read port i is taken at a rising edge
// when ren[i]=1 and its data appears on rd_data one edge later; a write is taken
// at a rising edge when we=1. Both are only honoured once init_done=1 (writes
// before that are dropped, read data is forced to zero).
interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic                 init_done;
   logic [NRD-1:0]       ren;
   logic [NRD*AW-1:0]    rs_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic                 we;
   logic [AW-1:0]        wa;
   logic [XLEN-1:0]      wd;

   modport master (input init_done, rd_data, output ren, rs_addr, we, wa, wd);
   modport slave  (output init_done, rd_data, input ren, rs_addr, we, wa, wd);
endinterface

// File: rtl/regfile_mp.sv
// Clocked multi-read-port register file with registered reads, optional
// write-to-read bypass, optional hardwired zero entry and a clear sequence
// that zeroes every entry after reset before writes are accepted.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_mp_if.slave  bus,
   output logic         dbg_state
);
   localparam int AW = $clog2(NREGS);
   localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 1);

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   state_t              state;
   state_t              next_state;
   logic [AW-1:0]       clr_ptr;
   logic [XLEN-1:0]     mem [NREGS];
   logic [XLEN-1:0]     rd_q [NRD];
   logic [XLEN-1:0]     rd_val [NRD];
   logic [AW-1:0]       rd_addr [NRD];
   logic [NRD*XLEN-1:0] rd_flat;
   logic                clr_en;
   logic                wr_en;
   logic                wr_ok;

   // Address is a real entry (NREGS need not be a power of two).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return int'({1'b0, a}) < NREGS;
   endfunction

   // State register: reset always restarts the clear sequence.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= CLEAR;
      else        state <= next_state;
   end

   // Next state: leave CLEAR once the last entry is being zeroed.
   always_comb begin
      next_state = state;
      case (state)
         CLEAR: if (clr_ptr == LAST_PTR) next_state = READY;
         READY: next_state = READY;
      endcase
   end

   // FSM outputs: status, clear strobe and qualified write.
   always_comb begin
      bus.init_done = (state == READY);
      clr_en        = (state == CLEAR);
      wr_en         = (state == READY) && bus.we;
   end

   assign dbg_state = state;

   // Write lands only on a real, non-hardwired entry.
   assign wr_ok = wr_en && addr_ok(bus.wa) && !(ZERO_REG != 0 && bus.wa == '0);

   // Clear pointer saturates on the last entry so it never wraps past NREGS-1.
   always_ff @(posedge clk) begin
      if (!rst_n)                             clr_ptr <= '0;
      else if (clr_en && clr_ptr != LAST_PTR) clr_ptr <= clr_ptr + 1'b1;
   end

   // Storage: zeroed one entry per cycle during CLEAR, written in READY; reset leaves it alone.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_en)     mem[clr_ptr] <= '0;
         else if (wr_ok) mem[bus.wa]  <= bus.wd;
      end
   end

   // Per-port read value: out-of-range, then zero entry, then bypass, then storage.
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_addr[i] = bus.rs_addr[i*AW +: AW];
         if (!addr_ok(rd_addr[i]))
            rd_val[i] = '0;
         else if (ZERO_REG != 0 && rd_addr[i] == '0)
            rd_val[i] = '0;
         else if (BYPASS != 0 && wr_en && bus.wa == rd_addr[i])
            rd_val[i] = bus.wd;
         else
            rd_val[i] = mem[rd_addr[i]];
      end
   end

   // Read registers: zero in reset and CLEAR, load on ren, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_en) begin
         for (int i = 0; i < NRD; i++) rd_q[i] <= '0;
      end else begin
         for (int i = 0; i < NRD; i++)
            if (bus.ren[i]) rd_q[i] <= rd_val[i];
      end
   end

   // Pack per-port read registers onto the bus.
   always_comb begin
      rd_flat = '0;
      for (int i = 0; i < NRD; i++) rd_flat[i*XLEN +: XLEN] = rd_q[i];
   end

   assign bus.rd_data = rd_flat;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised, clocked multi-read-port register file. It is the successor to the current combinational register file and sits between the decode and write-back stages of the core. It adds registered reads with per-port enable/hold, an optional write-to-read bypass, an optional hardwired-zero register, and a self-clearing init sequence after reset.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (>=2, need not be a power of 2)
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 is hardwired to zero (writes dropped, reads return 0)
BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read; 0 = read returns pre-write value
AW (localparam), $clog2(NREGS), address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
init_done  out  1  1 when the clear sequence is complete and the file accepts writes
ren  in  NRD  per-port read enable
rs_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NRD*XLEN  packed registered read data; port i uses bits [i*XLEN +: XLEN]
we  in  1  write enable
wa  in  AW  write address
wd  in  XLEN  write data

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state <= CLEAR; clr_ptr <= 0; init_done <= 0; all rd_data <= 0.
  - Memory contents are not touched by reset itself.
- FSM has 2 states:
  - CLEAR: each cycle mem[clr_ptr] <= 0 and clr_ptr++. When clr_ptr == NREGS-1 is written, go to READY. CLEAR lasts exactly NREGS cycles after rst_n rises.
  - READY: init_done = 1. Stays here until the next reset.
- During CLEAR:
  - we is ignored.
  - rd_data holds 0 regardless of ren.
- Reset asserted mid-CLEAR or mid-READY returns to CLEAR with clr_ptr=0, so the clear restarts from entry 0.
- Write (READY only): mem[wa] <= wd on the edge when we=1. The write is dropped when ZERO_REG=1 and wa==0, or when wa >= NREGS.
- Read, per port i, with 1-cycle latency:
  - ren[i]=1 at edge: rd_data_i <= value(rs_addr_i).
  - ren[i]=0: rd_data_i holds its previous value. This is an explicit register, not a latch.
- value(a) is resolved in priority order:
  - 0 if a >= NREGS;
  - else 0 if ZERO_REG=1 and a==0;
  - else wd if BYPASS=1, we=1, state=READY, wa==a;
  - else mem[a].
- Multiple ports may read the same address in the same cycle; all receive identical data.
- Only one write port exists, so there are no write-write conflicts.
- No arithmetic on data. clr_ptr is AW bits wide and must not wrap past NREGS-1.

Test Plan:
- Init: hold rst_n=0 for 3 cycles, release -> init_done=0 for exactly 32 cycles then 1; ren=2'b11 with rs_addr={5'd7,5'd3} gives rd_data=0 on both ports.
- Write/read: we=1, wa=5, wd=32'hDEADBEEF; next cycle ren[0]=1, rs_addr0=5 -> rd_data0=32'hDEADBEEF one cycle later; ren[0]=0 afterwards -> value held while wd/addr change.
- Zero reg: we=1, wa=0, wd=32'hFFFFFFFF, then read addr 0 on both ports -> 0. Repeat with ZERO_REG=0 -> 32'hFFFFFFFF.
- Bypass: mem[9]=32'h11; same cycle we=1, wa=9, wd=32'h22, ren[1]=1, rs_addr1=9 -> rd_data1=32'h22 with BYPASS=1, 32'h11 with BYPASS=0; following read returns 32'h22 in both builds.
- Reset mid-op: load x1..x4 with nonzero values, pulse rst_n low 1 cycle -> init_done drops; a write attempted during CLEAR is ignored; after init_done rises, x1..x4 read 0.
- Non-pow2: NREGS=24, NRD=3 -> CLEAR lasts 24 cycles; write to wa=30 is dropped; read addr 30 returns 0; three ports reading 1, 2, 1 in the same cycle return correct, matching data.
